// File: rtl/next_pc_unit.sv
// next_pc_unit
// Back end of the fetch PC loop. Produces the value the fetch-stage PC
// register loads each cycle. It resolves branch, jump and jr/jalr
// redirects for the instruction in decode, using MIPS single-delay-slot
// semantics. A redirect resolved while fetch is stalled is held in a
// pending register and released when the stall ends.
//
// Ports:
//   clk                  system clock, rising edge
//   reset                asynchronous active-high reset
//   pc_seq_in            fetch-stage PC+4
//   fetch_stall_in       fetch PC register not loading this cycle
//   dec_valid_in         decode holds a real instruction
//   dec_instr_in         instruction in decode
//   dec_pc_seq_in        decode instruction's PC+4 (delay-slot address)
//   branch_taken_in      condition result for conditional branches
//   rs_value_in          forwarded rs value for jr/jalr
//   next_pc_out          next PC for the fetch stage
//   redirect_pending_out a redirect is held in the pending register
//   in_delay_slot_out    decode instruction is a delay slot
//   ds_ctrl_err_out      one-cycle pulse: control transfer in a delay slot
//   redirect_count_out   saturating count of redirects taken
module next_pc_unit #(
  parameter logic [31:0] RESET_VECTOR = 32'h00400000,
  parameter int          CNT_W        = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      pc_seq_in,
  input  logic             fetch_stall_in,
  input  logic             dec_valid_in,
  input  logic [31:0]      dec_instr_in,
  input  logic [31:0]      dec_pc_seq_in,
  input  logic             branch_taken_in,
  input  logic [31:0]      rs_value_in,
  output logic [31:0]      next_pc_out,
  output logic             redirect_pending_out,
  output logic             in_delay_slot_out,
  output logic             ds_ctrl_err_out,
  output logic [CNT_W-1:0] redirect_count_out
);

  typedef enum logic [0:0] {
    ST_RUN  = 1'b0,
    ST_PEND = 1'b1
  } state_t;

  state_t           state_r;
  state_t           state_nxt_s;
  logic             first_r;
  logic [31:0]      pend_target_r;
  logic             in_ds_r;
  logic             ds_err_r;
  logic [CNT_W-1:0] count_r;

  logic [5:0]  opcode_s;
  logic [5:0]  funct_s;
  logic        is_br_s;
  logic        is_j_s;
  logic        is_jr_s;
  logic        ctl_s;
  logic        redirect_s;
  logic [31:0] br_offset_s;
  logic [31:0] target_s;
  logic        capture_s;
  logic        count_inc_s;
  logic [31:0] fsm_pc_s;

  assign opcode_s = dec_instr_in[31:26];
  assign funct_s  = dec_instr_in[5:0];

  // Instruction class decode for the instruction in decode.
  always_comb begin
    is_br_s = ((opcode_s >= 6'h04) && (opcode_s <= 6'h07)) || (opcode_s == 6'h01);
    is_j_s  = (opcode_s == 6'h02) || (opcode_s == 6'h03);
    is_jr_s = (opcode_s == 6'h00) && ((funct_s == 6'h08) || (funct_s == 6'h09));
  end

  assign ctl_s = dec_valid_in & (is_br_s | is_j_s | is_jr_s);

  // A transfer sitting in a delay slot is ignored. Nothing is issued in the
  // first post-reset cycle, because that cycle always fetches RESET_VECTOR.
  assign redirect_s = ctl_s & ~in_ds_r & ~first_r &
                      (is_j_s | is_jr_s | (is_br_s & branch_taken_in));

  assign br_offset_s = {{14{dec_instr_in[15]}}, dec_instr_in[15:0], 2'b00};

  // Redirect target selection; additions wrap modulo 2^32.
  always_comb begin
    target_s = dec_pc_seq_in + br_offset_s;
    if (is_jr_s) begin
      target_s = rs_value_in;
    end else if (is_j_s) begin
      target_s = {dec_pc_seq_in[31:28], dec_instr_in[25:0], 2'b00};
    end else begin
      target_s = dec_pc_seq_in + br_offset_s;
    end
  end

  // FSM next state and PC selection.
  always_comb begin
    state_nxt_s = state_r;
    capture_s   = 1'b0;
    fsm_pc_s    = pc_seq_in;
    case (state_r)
      ST_RUN: begin
        if (redirect_s) begin
          if (fetch_stall_in) begin
            // Fetch will ignore this cycle's value, so hold the target.
            state_nxt_s = ST_PEND;
            capture_s   = 1'b1;
            fsm_pc_s    = pc_seq_in;
          end else begin
            state_nxt_s = ST_RUN;
            fsm_pc_s    = target_s;
          end
        end else begin
          state_nxt_s = ST_RUN;
          fsm_pc_s    = pc_seq_in;
        end
      end
      ST_PEND: begin
        fsm_pc_s = pend_target_r;
        if (!fetch_stall_in) begin
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_PEND;
        end
      end
      default: begin
        state_nxt_s = ST_RUN;
        fsm_pc_s    = pc_seq_in;
      end
    endcase
  end

  // A redirect is counted once: either when it is issued or when it is captured.
  assign count_inc_s = redirect_s & (state_r == ST_RUN);

  // FSM state, first-cycle flag and pending target.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_RUN;
      first_r       <= 1'b1;
      pend_target_r <= 32'h00000000;
    end else begin
      state_r <= state_nxt_s;
      first_r <= 1'b0;
      if (capture_s) begin
        pend_target_r <= target_s;
      end
    end
  end

  // Delay-slot tracking: it only advances on edges where fetch accepts.
  // A transfer found in a slot clears the flag instead of re-arming it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_ds_r  <= 1'b0;
      ds_err_r <= 1'b0;
    end else if (!fetch_stall_in) begin
      ds_err_r <= ctl_s & in_ds_r;
      in_ds_r  <= in_ds_r ? 1'b0 : ctl_s;
    end else begin
      ds_err_r <= 1'b0;
    end
  end

  // Saturating taken-redirect counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_r <= {CNT_W{1'b0}};
    end else if (count_inc_s && (count_r != {CNT_W{1'b1}})) begin
      count_r <= count_r + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  assign next_pc_out          = first_r ? RESET_VECTOR : fsm_pc_s;
  assign redirect_pending_out = (state_r == ST_PEND);
  assign in_delay_slot_out    = in_ds_r;
  assign ds_ctrl_err_out      = ds_err_r;
  assign redirect_count_out   = count_r;

endmodule

// File: tb/tb_next_pc_unit.sv
module tb_next_pc_unit;
  localparam logic [31:0] RV = 32'h00400000;
  localparam int          CW = 4;

  localparam logic [31:0] NOP = 32'h00000000;
  localparam logic [31:0] BEQ = 32'h1000FFFF;
  localparam logic [31:0] BNE = 32'h14000004;
  localparam logic [31:0] JMP = 32'h08100040;
  localparam logic [31:0] JR  = 32'h03E00008;

  logic          clk = 1'b0;
  logic          reset;
  logic [31:0]   pc_seq;
  logic          stall;
  logic          dvalid;
  logic [31:0]   instr;
  logic [31:0]   dseq;
  logic          taken;
  logic [31:0]   rs;
  logic [31:0]   next_pc;
  logic          pending;
  logic          in_ds;
  logic          ds_err;
  logic [CW-1:0] count;

  int tests_run = 0;
  int failed    = 0;

  next_pc_unit #(.RESET_VECTOR(RV), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .pc_seq_in(pc_seq), .fetch_stall_in(stall),
    .dec_valid_in(dvalid), .dec_instr_in(instr), .dec_pc_seq_in(dseq),
    .branch_taken_in(taken), .rs_value_in(rs), .next_pc_out(next_pc),
    .redirect_pending_out(pending), .in_delay_slot_out(in_ds),
    .ds_ctrl_err_out(ds_err), .redirect_count_out(count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] ds,
                       input logic tk, input logic st, input logic [31:0] ps,
                       input logic [31:0] r);
    dvalid = v; instr = ins; dseq = ds; taken = tk; stall = st; pc_seq = ps; rs = r;
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(1'b0, NOP, 32'h0, 1'b0, 1'b0, 32'h00400004, 32'h0);
    tick(); tick();
    tests_run++; if (next_pc !== RV) begin failed++; $display("FAIL reset_pc: got %h want %h", next_pc, RV); end
    tests_run++; if ({pending, in_ds, ds_err} !== 3'b000) begin failed++; $display("FAIL reset_flags: got %b want 000", {pending, in_ds, ds_err}); end
    tests_run++; if (count !== 4'd0) begin failed++; $display("FAIL reset_count: got %0d want 0", count); end
    reset = 1'b0;
    #1;
    tests_run++; if (next_pc !== RV) begin failed++; $display("FAIL first_cycle_pc: got %h want %h", next_pc, RV); end
    tick();
    tests_run++; if (next_pc !== 32'h00400004) begin failed++; $display("FAIL seq_pc1: got %h want 00400004", next_pc); end
    drive(1'b0, NOP, 32'h0, 1'b0, 1'b0, 32'h00400008, 32'h0);
    tests_run++; if (next_pc !== 32'h00400008) begin failed++; $display("FAIL seq_pc2: got %h want 00400008", next_pc); end
    tick();
    tests_run++; if (count !== 4'd0) begin failed++; $display("FAIL seq_count: got %0d want 0", count); end
  endtask

  task automatic test_taken_beq();
    drive(1'b1, BEQ, 32'h00400010, 1'b1, 1'b0, 32'h00400014, 32'h0);
    tests_run++; if (next_pc !== 32'h0040000C) begin failed++; $display("FAIL beq_target: got %h want 0040000c", next_pc); end
    tick();
    tests_run++; if (in_ds !== 1'b1) begin failed++; $display("FAIL beq_in_ds: got %b want 1", in_ds); end
    tests_run++; if (count !== 4'd1) begin failed++; $display("FAIL beq_count: got %0d want 1", count); end
    drive(1'b1, NOP, 32'h00400014, 1'b0, 1'b0, 32'h00400010, 32'h0);
    tests_run++; if (next_pc !== 32'h00400010) begin failed++; $display("FAIL beq_slot_pc: got %h want 00400010", next_pc); end
    tick();
    tests_run++; if (in_ds !== 1'b0) begin failed++; $display("FAIL beq_ds_clear: got %b want 0", in_ds); end
  endtask

  task automatic test_bne_then_j();
    drive(1'b1, BNE, 32'h00400018, 1'b0, 1'b0, 32'h0040001C, 32'h0);
    tests_run++; if (next_pc !== 32'h0040001C) begin failed++; $display("FAIL bne_no_redirect: got %h want 0040001c", next_pc); end
    tick();
    tests_run++; if ({in_ds, count} !== {1'b1, 4'd1}) begin failed++; $display("FAIL bne_state: got ds=%b cnt=%0d want ds=1 cnt=1", in_ds, count); end
    drive(1'b1, NOP, 32'h0040001C, 1'b0, 1'b0, 32'h00400020, 32'h0);
    tick();
    drive(1'b1, JMP, 32'h00400020, 1'b0, 1'b0, 32'h00400024, 32'h0);
    tests_run++; if (next_pc !== 32'h00400100) begin failed++; $display("FAIL j_target: got %h want 00400100", next_pc); end
    tick();
    tests_run++; if ({in_ds, count} !== {1'b1, 4'd2}) begin failed++; $display("FAIL j_state: got ds=%b cnt=%0d want ds=1 cnt=2", in_ds, count); end
    drive(1'b1, NOP, 32'h00400024, 1'b0, 1'b0, 32'h00400104, 32'h0);
    tick();
  endtask

  task automatic test_redirect_stall();
    drive(1'b1, JR, 32'h0040002C, 1'b0, 1'b1, 32'h00400030, 32'h00400200);
    tests_run++; if ({pending, next_pc} !== {1'b0, 32'h00400030}) begin failed++; $display("FAIL jr_capture_cycle: got p=%b pc=%h want p=0 pc=00400030", pending, next_pc); end
    tick();
    for (int i = 0; i < 3; i++) begin
      if (i == 2) drive(1'b1, JR, 32'h0040002C, 1'b0, 1'b0, 32'h00400030, 32'h00400200);
      tests_run++; if ({pending, next_pc} !== {1'b1, 32'h00400200}) begin failed++; $display("FAIL jr_pending_%0d: got p=%b pc=%h want p=1 pc=00400200", i, pending, next_pc); end
      tests_run++; if (in_ds !== 1'b0) begin failed++; $display("FAIL jr_ds_held_%0d: got %b want 0", i, in_ds); end
      tick();
    end
    tests_run++; if ({pending, in_ds, count} !== {1'b0, 1'b1, 4'd3}) begin failed++; $display("FAIL jr_release: got p=%b ds=%b cnt=%0d want p=0 ds=1 cnt=3", pending, in_ds, count); end
    drive(1'b1, NOP, 32'h00400030, 1'b0, 1'b0, 32'h00400204, 32'h0);
    tests_run++; if (next_pc !== 32'h00400204) begin failed++; $display("FAIL jr_after_pc: got %h want 00400204", next_pc); end
    tick();
  endtask

  task automatic test_branch_in_slot();
    drive(1'b1, BEQ, 32'h00400040, 1'b1, 1'b0, 32'h00400044, 32'h0);
    tests_run++; if (next_pc !== 32'h0040003C) begin failed++; $display("FAIL slot_first_beq: got %h want 0040003c", next_pc); end
    tick();
    tests_run++; if ({in_ds, ds_err, count} !== {1'b1, 1'b0, 4'd4}) begin failed++; $display("FAIL slot_armed: got ds=%b err=%b cnt=%0d want 1 0 4", in_ds, ds_err, count); end
    drive(1'b1, BEQ, 32'h00400044, 1'b1, 1'b0, 32'h00400040, 32'h0);
    tests_run++; if (next_pc !== 32'h00400040) begin failed++; $display("FAIL slot_ignored_pc: got %h want 00400040", next_pc); end
    tick();
    tests_run++; if ({in_ds, ds_err, count} !== {1'b0, 1'b1, 4'd4}) begin failed++; $display("FAIL slot_err_pulse: got ds=%b err=%b cnt=%0d want 0 1 4", in_ds, ds_err, count); end
    drive(1'b1, NOP, 32'h00400044, 1'b0, 1'b0, 32'h00400048, 32'h0);
    tick();
    tests_run++; if ({in_ds, ds_err} !== 2'b00) begin failed++; $display("FAIL slot_err_clear: got ds=%b err=%b want 0 0", in_ds, ds_err); end
  endtask

  task automatic test_reset_in_pend();
    drive(1'b1, JR, 32'h00400050, 1'b0, 1'b1, 32'h00400054, 32'h00400300);
    tick();
    tests_run++; if ({pending, next_pc, count} !== {1'b1, 32'h00400300, 4'd5}) begin failed++; $display("FAIL pend2_enter: got p=%b pc=%h cnt=%0d want 1 00400300 5", pending, next_pc, count); end
    #2;
    reset = 1'b1;
    #1;
    tests_run++; if (next_pc !== RV) begin failed++; $display("FAIL async_reset_pc: got %h want %h", next_pc, RV); end
    tests_run++; if ({pending, count} !== {1'b0, 4'd0}) begin failed++; $display("FAIL async_reset_state: got p=%b cnt=%0d want 0 0", pending, count); end
    drive(1'b0, NOP, 32'h0, 1'b0, 1'b0, 32'h00400004, 32'h0);
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_saturation();
    for (int i = 0; i < 17; i++) begin
      drive(1'b1, JMP, 32'h00400020, 1'b0, 1'b0, 32'h00400008, 32'h0);
      tick();
      drive(1'b1, NOP, 32'h00400024, 1'b0, 1'b0, 32'h00400104, 32'h0);
      tick();
      if (i == 13) begin
        tests_run++; if (count !== 4'd14) begin failed++; $display("FAIL sat_below: got %0d want 14", count); end
      end
    end
    tests_run++; if (count !== 4'd15) begin failed++; $display("FAIL sat_hold: got %0d want 15", count); end
  endtask

  initial begin
    test_reset();
    test_taken_beq();
    test_bne_then_j();
    test_redirect_stall();
    test_branch_in_slot();
    test_reset_in_pend();
    test_saturation();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end
endmodule
